// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;
  localparam int              PC_W      = 32;
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0000;
  localparam logic [PC_W-1:0] PC_STEP   = PC_W'(4);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} fetchState_t;
endpackage

// File: rtl/fetch_stage_flopenrc.sv
// Flop with async reset, enable and synchronous clear (clear wins over enable).
module flopenrc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end
endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, instruction-memory handshake FSM, one-entry hold buffer, IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ImemReqF,
  output logic [31:0] ImemAddrF,
  input  logic [31:0] ImemRdata,
  input  logic        ImemValid,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic [6:0]  opD,
  output logic [2:0]  funct3D,
  output logic        funct7b5D,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic [4:0]  RdD
);
  localparam int IFID_W = 32 + 2 * PC_W;

  fetchState_t     state, stateN;
  logic [PC_W-1:0] PCF, pcN, ReqAddr, reqAddrN, holdPC, holdPCN;
  logic [31:0]     holdInstr, holdInstrN, ifInstr;
  logic [PC_W-1:0] ifPC;
  logic            ifLoad, ifClr;
  logic [IFID_W-1:0] ifidQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      PCF       <= RESET_PC;
      ReqAddr   <= RESET_PC;
      holdInstr <= NOP_INSTR;
      holdPC    <= '0;
    end else begin
      state     <= stateN;
      PCF       <= pcN;
      ReqAddr   <= reqAddrN;
      holdInstr <= holdInstrN;
      holdPC    <= holdPCN;
    end
  end

  always_comb begin
    stateN     = state;
    pcN        = PCF;
    reqAddrN   = ReqAddr;
    holdInstrN = holdInstr;
    holdPCN    = holdPC;
    ifLoad     = 1'b0;
    ifInstr    = NOP_INSTR;
    ifPC       = '0;
    ImemReqF   = 1'b0;
    unique case (state)
      IDLE: begin
        stateN   = REQ;
        reqAddrN = PCF;
      end
      REQ: begin
        ImemReqF = 1'b1;
        if (PCSrcE) begin
          // A response arriving with the redirect is wrong-path; a missing one must be drained in DROP.
          pcN = PCTargetE;
          if (ImemValid) reqAddrN = PCTargetE;
          else           stateN   = DROP;
        end else if (ImemValid) begin
          pcN = PCF + PC_STEP;
          if (StallD) begin
            holdInstrN = ImemRdata;
            holdPCN    = PCF;
            stateN     = HOLD;
          end else begin
            reqAddrN = PCF + PC_STEP;
            ifLoad   = 1'b1;
            ifInstr  = ImemRdata;
            ifPC     = PCF;
          end
        end
      end
      HOLD: begin
        if (PCSrcE) begin
          pcN      = PCTargetE;
          reqAddrN = PCTargetE;
          stateN   = REQ;
        end else if (!StallD) begin
          ifLoad   = 1'b1;
          ifInstr  = holdInstr;
          ifPC     = holdPC;
          reqAddrN = PCF;
          stateN   = REQ;
        end
      end
      DROP: begin
        ImemReqF = 1'b1;
        if (PCSrcE) pcN = PCTargetE;
        if (ImemValid) begin
          reqAddrN = pcN;
          stateN   = REQ;
        end
      end
      default: stateN = IDLE;
    endcase
  end

  assign ImemAddrF = ReqAddr;

  // Anything other than a real load while not stalled becomes a bubble.
  assign ifClr = FlushD | (~StallD & ~ifLoad);

  flopenrc #(.WIDTH(IFID_W)) ifidReg (
    .clk  (clk),
    .reset(reset),
    .en   (ifLoad),
    .clr  (ifClr),
    .d    ({ifInstr, ifPC, ifPC + PC_STEP}),
    .q    (ifidQ)
  );

  assign {InstrD, PCD, PCPlus4D} = ifidQ;
  assign opD       = InstrD[6:0];
  assign funct3D   = InstrD[14:12];
  assign funct7b5D = InstrD[30];
  assign Rs1D      = InstrD[19:15];
  assign Rs2D      = InstrD[24:20];
  assign RdD       = InstrD[11:7];
endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage with a scoreboard of instructions headed for decode.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset, StallD, FlushD, PCSrcE, ImemValid;
  logic [31:0] PCTargetE, ImemRdata, ImemAddrF, InstrD, PCD, PCPlus4D;
  logic        ImemReqF, funct7b5D;
  logic [6:0]  opD;
  logic [2:0]  funct3D;
  logic [4:0]  Rs1D, Rs2D, RdD;

  fetch_stage #(.RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .StallD(StallD), .FlushD(FlushD), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .ImemReqF(ImemReqF), .ImemAddrF(ImemAddrF),
    .ImemRdata(ImemRdata), .ImemValid(ImemValid), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memData(input logic [31:0] a);
    if (a == 32'h4) return 32'h0050_0093;
    return {a[29:0], 2'b11} ^ 32'h5A5A_0000;
  endfunction

  assign ImemRdata = memData(ImemAddrF);

  typedef enum logic [1:0] {K_LOAD, K_BUBBLE, K_KEEP} kind_t;
  typedef struct {
    logic        stall, flush, pcsrc, valid;
    logic [31:0] target;
    logic        req;
    logic [31:0] addr;
    logic        push;
    kind_t       kind;
  } vec_t;
  typedef struct { logic [31:0] instr, pc; } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          nVec = 0, nErr = 0;
  logic [31:0] expInstr = 32'h0, expPC = 32'h0, expPC4 = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic popExp(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      nVec++; nErr++;
      $display("FAIL %s: scoreboard empty at %0t", name, $time);
    end else begin
      e = sb.pop_front();
      expInstr = e.instr; expPC = e.pc; expPC4 = e.pc + 32'd4;
    end
  endtask

  task automatic chkIfId(input string name);
    chk({name, ".InstrD"}, InstrD, expInstr);
    chk({name, ".PCD"}, PCD, expPC);
    chk({name, ".PCPlus4D"}, PCPlus4D, expPC4);
    chk({name, ".fields"}, {6'b0, opD, funct3D, funct7b5D, Rs1D, Rs2D, RdD},
        {6'b0, expInstr[6:0], expInstr[14:12], expInstr[30], expInstr[19:15],
         expInstr[24:20], expInstr[11:7]});
  endtask

  function automatic vec_t mk(input logic st, fl, ps, va, input logic [31:0] tg,
                              input logic rq, input logic [31:0] ad, input logic pu,
                              input kind_t k);
    vec_t v;
    v.stall = st; v.flush = fl; v.pcsrc = ps; v.valid = va; v.target = tg;
    v.req = rq; v.addr = ad; v.push = pu; v.kind = k;
    return v;
  endfunction

  // Entered and left at a negative clock edge.
  task automatic applyVec(input int i, input vec_t v);
    string n;
    n = $sformatf("v%0d", i);
    StallD = v.stall; FlushD = v.flush; PCSrcE = v.pcsrc; ImemValid = v.valid;
    PCTargetE = v.target;
    #1;
    chk({n, ".ImemReqF"}, 32'(ImemReqF), 32'(v.req));
    if (v.req) chk({n, ".ImemAddrF"}, ImemAddrF, v.addr);
    if (v.push) sb.push_back('{memData(v.addr), v.addr});
    @(posedge clk); #1;
    case (v.kind)
      K_LOAD:   popExp(n);
      K_BUBBLE: begin expInstr = 32'h0; expPC = 32'h0; expPC4 = 32'h0; end
      default:  ;
    endcase
    chkIfId(n);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; StallD = 0; FlushD = 0; PCSrcE = 0; ImemValid = 0; PCTargetE = 0;
    //        st fl ps va target        req addr          push kind
    vecs.push_back(mk(0,0,0,1, 32'h0,        0, 32'h0,        0, K_BUBBLE)); // IDLE
    vecs.push_back(mk(0,0,0,1, 32'h0,        1, 32'h0,        1, K_LOAD));
    vecs.push_back(mk(1,0,0,1, 32'h0,        1, 32'h4,        1, K_KEEP));   // into HOLD
    vecs.push_back(mk(1,0,0,0, 32'h0,        0, 32'h0,        0, K_KEEP));
    vecs.push_back(mk(0,0,0,0, 32'h0,        0, 32'h0,        0, K_LOAD));   // hold -> decode
    vecs.push_back(mk(0,0,0,0, 32'h0,        1, 32'h8,        0, K_BUBBLE)); // wait states
    vecs.push_back(mk(0,0,0,0, 32'h0,        1, 32'h8,        0, K_BUBBLE));
    vecs.push_back(mk(0,0,0,0, 32'h0,        1, 32'h8,        0, K_BUBBLE));
    vecs.push_back(mk(0,0,0,1, 32'h0,        1, 32'h8,        1, K_LOAD));
    vecs.push_back(mk(0,0,1,0, 32'h40,       1, 32'hC,        0, K_BUBBLE)); // -> DROP
    vecs.push_back(mk(0,0,0,0, 32'h0,        1, 32'hC,        0, K_BUBBLE));
    vecs.push_back(mk(0,0,0,1, 32'h0,        1, 32'hC,        0, K_BUBBLE)); // late data dropped
    vecs.push_back(mk(0,0,0,1, 32'h0,        1, 32'h40,       1, K_LOAD));
    vecs.push_back(mk(1,1,0,1, 32'h0,        1, 32'h44,       1, K_BUBBLE)); // flush beats stall
    vecs.push_back(mk(0,0,0,0, 32'h0,        0, 32'h0,        0, K_LOAD));
    vecs.push_back(mk(0,0,1,1, 32'hFFFF_FFFC,1, 32'h48,       0, K_BUBBLE));
    vecs.push_back(mk(0,0,0,1, 32'h0,        1, 32'hFFFF_FFFC,1, K_LOAD));   // wrap
    vecs.push_back(mk(0,0,0,1, 32'h0,        1, 32'h0,        1, K_LOAD));
    vecs.push_back(mk(1,0,1,1, 32'h100,      1, 32'h4,        0, K_KEEP));   // redirect over stall
    vecs.push_back(mk(0,0,0,1, 32'h0,        1, 32'h100,      1, K_LOAD));
    vecs.push_back(mk(1,0,0,1, 32'h0,        1, 32'h104,      0, K_KEEP));   // into HOLD
    vecs.push_back(mk(0,0,1,0, 32'h200,      0, 32'h0,        0, K_BUBBLE)); // redirect empties hold
    vecs.push_back(mk(0,0,0,1, 32'h0,        1, 32'h200,      1, K_LOAD));
    vecs.push_back(mk(0,0,0,0, 32'h0,        1, 32'h204,      0, K_BUBBLE));

    @(negedge clk); @(negedge clk);
    chk("rst.ImemReqF", 32'(ImemReqF), 32'h0);
    chkIfId("rst");
    reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) applyVec(i, vecs[i]);

    // Reset while a request is pending, with a response pulsed during reset.
    ImemValid = 1'b0; StallD = 0; FlushD = 0; PCSrcE = 0;
    #2 reset = 1'b1;
    #1;
    expInstr = 32'h0; expPC = 32'h0; expPC4 = 32'h0;
    chk("midrst.ImemReqF", 32'(ImemReqF), 32'h0);
    chkIfId("midrst");
    ImemValid = 1'b1;
    @(posedge clk); #1;
    chkIfId("midrst2");
    @(negedge clk);
    reset = 1'b0;
    #1 chk("idle.ImemReqF", 32'(ImemReqF), 32'h0);
    @(posedge clk); #1;
    chk("rel.ImemReqF", 32'(ImemReqF), 32'h1);
    chk("rel.ImemAddrF", ImemAddrF, 32'h0);
    chkIfId("rel");
    sb.push_back('{memData(32'h0), 32'h0});
    @(posedge clk); #1;
    popExp("first");
    chkIfId("first");
    chk("sb.empty", sb.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
